udi_cmd_issuer: RTL



---
 rtl/udi_cmd_issuer_pkg.sv | 28 ++
 rtl/udi_stall_timer.sv | 35 +++
 rtl/udi_cmd_issuer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/udi_cmd_issuer_pkg.sv
// UDI command issuer shared definitions.
// Opcode fields, status codes and FSM state encoding.
package udi_cmd_issuer_pkg;

  localparam logic [5:0] UDI_MAJOR = 6'd28;
  localparam logic [5:0] FN_LO     = 6'd16;
  localparam logic [5:0] FN_HI     = 6'd22;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_RI   = 2'b01;
  localparam logic [1:0] ST_TMO  = 2'b10;
  localparam logic [1:0] ST_KILL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_DONE
  } state_e;

  function automatic logic [31:0] mk_ir(
    input logic [5:0] funct,
    input logic [4:0] rd
  );
    return {UDI_MAJOR, 5'd0, 5'd0, rd, 5'd0, funct};
  endfunction

endpackage

// File: rtl/udi_stall_timer.sv
// M-stage stall timer: saturating counter.
// Flags timeout once STALL cycles reach MAX.
module udi_stall_timer #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins; otherwise count stalls up to MAX and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != MAXV)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == MAXV);

endmodule

// File: rtl/udi_cmd_issuer.sv
// Core-side UDI initiator: host cmd -> E/M stage
// sequencing -> host response.
`ifndef M14K_UDI_EXT_TOUDI_WIDTH
`define M14K_UDI_EXT_TOUDI_WIDTH 1
`endif
module udi_cmd_issuer
  import udi_cmd_issuer_pkg::*;
#(
  parameter int STALL_MAX  = 16,
  parameter bit ENDIAN_BIG = 1'b0,
  parameter bit KD_MODE    = 1'b1
) (
  input  logic        UDI_gclk,
  input  logic        UDI_greset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_funct,
  input  logic [31:0] cmd_rs,
  input  logic [31:0] cmd_rt,
  input  logic [4:0]  cmd_rd,
  input  logic        cmd_abort,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic [1:0]  res_status,
  output logic [31:0] UDI_ir_e,
  output logic        UDI_irvalid_e,
  output logic        UDI_start_e,
  output logic [31:0] UDI_rs_e,
  output logic [31:0] UDI_rt_e,
  output logic        UDI_run_m,
  output logic        UDI_kill_m,
  output logic        UDI_endianb_e,
  output logic        UDI_kd_mode_e,
  output logic [`M14K_UDI_EXT_TOUDI_WIDTH-1:0] UDI_toudi,
  input  logic [31:0] UDI_rd_m,
  input  logic [4:0]  UDI_wrreg_e,
  input  logic        UDI_ri_e,
  input  logic        UDI_stall_m,
  input  logic        UDI_present
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic        irv_q, irv_d;
  logic        run_q, run_d;
  logic        rdy_q, rdy_d;
  logic        rv_q, rv_d;
  logic [31:0] dat_q, dat_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  st_q, st_d;
  logic        apend_q, apend_d;
  logic        kill, tmo, abort;

  udi_stall_timer #(
    .MAX(STALL_MAX)
  ) u_tmr (
    .clk    (UDI_gclk),
    .rst    (UDI_greset),
    .clr    (state_q == S_EXEC),
    .en     (state_q == S_MEM && UDI_stall_m),
    .timeout(tmo)
  );

  // Next-state and next-output logic for the E/M sequencer.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    irv_d   = 1'b0;
    run_d   = 1'b0;
    rdy_d   = rdy_q;
    rv_d    = rv_q;
    dat_d   = dat_q;
    rd_d    = rd_q;
    st_d    = st_q;
    apend_d = 1'b0;
    kill    = 1'b0;
    abort   = cmd_abort | apend_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ir_d    = mk_ir(cmd_funct, cmd_rd);
          rs_d    = cmd_rs;
          rt_d    = cmd_rt;
          irv_d   = 1'b1;
          rdy_d   = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (UDI_ri_e || !UDI_present) begin
          st_d    = ST_RI;
          dat_d   = '0;
          rd_d    = '0;
          rv_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          rd_d    = UDI_wrreg_e;
          run_d   = 1'b1;
          apend_d = cmd_abort;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (abort) begin
          kill    = 1'b1;
          st_d    = ST_KILL;
          dat_d   = '0;
          rv_d    = 1'b1;
          state_d = S_DONE;
        end else if (UDI_stall_m && tmo) begin
          kill    = 1'b1;
          st_d    = ST_TMO;
          dat_d   = '0;
          rv_d    = 1'b1;
          state_d = S_DONE;
        end else if (!UDI_stall_m) begin
          st_d    = ST_OK;
          dat_d   = UDI_rd_m;
          rv_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          run_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          rv_d    = 1'b0;
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge UDI_gclk) begin
    if (UDI_greset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      irv_q   <= 1'b0;
      run_q   <= 1'b0;
      rdy_q   <= 1'b1;
      rv_q    <= 1'b0;
      dat_q   <= '0;
      rd_q    <= '0;
      st_q    <= '0;
      apend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      irv_q   <= irv_d;
      run_q   <= run_d;
      rdy_q   <= rdy_d;
      rv_q    <= rv_d;
      dat_q   <= dat_d;
      rd_q    <= rd_d;
      st_q    <= st_d;
      apend_q <= apend_d;
    end
  end

  assign cmd_ready     = rdy_q;
  assign res_valid     = rv_q;
  assign res_data      = dat_q;
  assign res_rd        = rd_q;
  assign res_status    = st_q;
  assign UDI_ir_e      = ir_q;
  assign UDI_irvalid_e = irv_q;
  assign UDI_start_e   = irv_q;
  assign UDI_rs_e      = rs_q;
  assign UDI_rt_e      = rt_q;
  assign UDI_run_m     = run_q;
  assign UDI_kill_m    = kill & ~UDI_greset;
  assign UDI_endianb_e = ENDIAN_BIG;
  assign UDI_kd_mode_e = KD_MODE;
  assign UDI_toudi     = '0;

endmodule
